// File: rtl/sobel_ctrl_if.sv
// Controller-side bundle for sobel_ctrl: frame control, source RAM read port,
// sobel_calc window/handshake and destination RAM write port.
interface sobel_ctrl_if #(
   parameter int ADDR_W = 16
);
   logic              start_i, busy_o, frame_done_o;
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [7:0]        rd_data_i;
   logic [7:0]        d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
   logic              calc_valid_o, calc_done_i;
   logic [7:0]        calc_pix_i;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [7:0]        wr_data_o;

   modport master (
      input  start_i, rd_data_i, calc_done_i, calc_pix_i,
      output busy_o, frame_done_o, rd_en_o, rd_addr_o,
             d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o,
             calc_valid_o, wr_en_o, wr_addr_o, wr_data_o
   );

   modport slave (
      output start_i, rd_data_i, calc_done_i, calc_pix_i,
      input  busy_o, frame_done_o, rd_en_o, rd_addr_o,
             d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o,
             calc_valid_o, wr_en_o, wr_addr_o, wr_data_o
   );
endinterface

// File: rtl/sobel_ctrl.sv
// Frame scheduler for sobel_calc: builds 3x3 windows from a sync-read source RAM
// with a column-shift window, one window in flight, results written in raster order.
module sobel_ctrl #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int ADDR_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   sobel_ctrl_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_WRITE, S_COL, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 2);
   localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 2);

   state_t            state;
   logic [ADDR_W-1:0] x, y, wcnt;
   logic [1:0]        ri, ci, nr, nc;
   logic              cap_vld;
   logic [3:0]        cap_slot;
   logic [7:0]        win [9];
   logic              busy, frame_done, rd_en, calc_valid, wr_en;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [7:0]        wr_data;

   // (r,c) is the offset of the read inside the window anchored at (x-1,y-1)
   function automatic logic [ADDR_W-1:0] raddr(input logic [ADDR_W-1:0] yy, xx,
                                                input logic [1:0] r, c);
      return (yy - ONE + ADDR_W'(r)) * W_A + (xx - ONE + ADDR_W'(c));
   endfunction

   // FILL walks column-major over all 9 cells; COL only walks rows of column 2
   always_comb begin
      nr = (ri == 2'd2) ? 2'd0 : ri + 2'd1;
      nc = (state == S_FILL && ri == 2'd2) ? ci + 2'd1 : ci;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         x          <= '0;
         y          <= '0;
         wcnt       <= '0;
         ri         <= '0;
         ci         <= '0;
         cap_vld    <= 1'b0;
         cap_slot   <= '0;
         for (int i = 0; i < 9; i++) win[i] <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         calc_valid <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         // read data returns one cycle after the strobe
         cap_vld  <= rd_en;
         cap_slot <= {2'b00, ri} * 4'd3 + {2'b00, ci};
         if (cap_vld) win[cap_slot] <= bus.rd_data_i;

         case (state)
            S_IDLE: if (bus.start_i) begin
               busy    <= 1'b1;
               x       <= ONE;
               y       <= ONE;
               wcnt    <= '0;
               ri      <= 2'd0;
               ci      <= 2'd0;
               rd_en   <= 1'b1;
               rd_addr <= raddr(ONE, ONE, 2'd0, 2'd0);
               state   <= S_FILL;
            end
            S_FILL, S_COL: begin
               if (rd_en) begin
                  if (ri == 2'd2 && ci == 2'd2) rd_en <= 1'b0;
                  else begin
                     ri      <= nr;
                     ci      <= nc;
                     rd_addr <= raddr(y, x, nr, nc);
                  end
               end else if (cap_vld) begin
                  calc_valid <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               calc_valid <= 1'b0;
               state      <= S_WAIT;
            end
            S_WAIT: if (bus.calc_done_i) begin
               wr_data <= bus.calc_pix_i;
               wr_addr <= wcnt;
               wcnt    <= wcnt + ONE;
               wr_en   <= 1'b1;
               state   <= S_WRITE;
            end
            S_WRITE: begin
               wr_en <= 1'b0;
               if (x < X_LAST) begin
                  x      <= x + ONE;
                  win[0] <= win[1];
                  win[1] <= win[2];
                  win[3] <= win[4];
                  win[4] <= win[5];
                  win[6] <= win[7];
                  win[7] <= win[8];
                  ri      <= 2'd0;
                  ci      <= 2'd2;
                  rd_en   <= 1'b1;
                  rd_addr <= raddr(y, x + ONE, 2'd0, 2'd2);
                  state   <= S_COL;
               end else if (y < Y_LAST) begin
                  y       <= y + ONE;
                  x       <= ONE;
                  ri      <= 2'd0;
                  ci      <= 2'd0;
                  rd_en   <= 1'b1;
                  rd_addr <= raddr(y + ONE, ONE, 2'd0, 2'd0);
                  state   <= S_FILL;
               end else begin
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= S_DONE;
               end
            end
            S_DONE: begin
               frame_done <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy_o       = busy;
   assign bus.frame_done_o = frame_done;
   assign bus.rd_en_o      = rd_en;
   assign bus.rd_addr_o    = rd_addr;
   assign bus.calc_valid_o = calc_valid;
   assign bus.wr_en_o      = wr_en;
   assign bus.wr_addr_o    = wr_addr;
   assign bus.wr_data_o    = wr_data;
   assign bus.d0_o = win[0];
   assign bus.d1_o = win[1];
   assign bus.d2_o = win[2];
   assign bus.d3_o = win[3];
   assign bus.d4_o = win[4];
   assign bus.d5_o = win[5];
   assign bus.d6_o = win[6];
   assign bus.d7_o = win[7];
   assign bus.d8_o = win[8];
endmodule

// File: tb/tb_sobel_ctrl.sv
// Bench for sobel_ctrl: 3x3, 4x4 and 8x3 instances driven by a cycle-stepped
// RAM/sobel_calc model, checked against windows and writes derived from the image.
module tb_sobel_ctrl;
   typedef logic [8:0][7:0] win_t;
   typedef struct packed {
      logic        busy, frame_done, rd_en;
      logic [15:0] rd_addr;
      logic        calc_valid, wr_en;
      logic [15:0] wr_addr;
      logic [7:0]  wr_data;
      win_t        d;
   } obs_t;

   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;

   int         sel = 0;
   logic       start = 1'b0, cdone = 1'b0;
   logic [7:0] cpix = '0, rd_data = '0;
   logic [7:0] mem [64];
   obs_t       ob [3];
   obs_t       o;

   sobel_ctrl_if #(.ADDR_W(16)) if3 (), if4 (), if83 ();
   sobel_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(16)) u3  (.clk(clk), .rst(rst), .bus(if3.master));
   sobel_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(16)) u4  (.clk(clk), .rst(rst), .bus(if4.master));
   sobel_ctrl #(.IMG_W(8), .IMG_H(3), .ADDR_W(16)) u83 (.clk(clk), .rst(rst), .bus(if83.master));

   assign if3.start_i      = start && sel == 0;
   assign if4.start_i      = start && sel == 1;
   assign if83.start_i     = start && sel == 2;
   assign if3.calc_done_i  = cdone && sel == 0;
   assign if4.calc_done_i  = cdone && sel == 1;
   assign if83.calc_done_i = cdone && sel == 2;
   assign if3.calc_pix_i   = cpix;
   assign if4.calc_pix_i   = cpix;
   assign if83.calc_pix_i  = cpix;
   assign if3.rd_data_i    = rd_data;
   assign if4.rd_data_i    = rd_data;
   assign if83.rd_data_i   = rd_data;

   assign ob[0] = {if3.busy_o, if3.frame_done_o, if3.rd_en_o, if3.rd_addr_o, if3.calc_valid_o,
                   if3.wr_en_o, if3.wr_addr_o, if3.wr_data_o, if3.d8_o, if3.d7_o, if3.d6_o,
                   if3.d5_o, if3.d4_o, if3.d3_o, if3.d2_o, if3.d1_o, if3.d0_o};
   assign ob[1] = {if4.busy_o, if4.frame_done_o, if4.rd_en_o, if4.rd_addr_o, if4.calc_valid_o,
                   if4.wr_en_o, if4.wr_addr_o, if4.wr_data_o, if4.d8_o, if4.d7_o, if4.d6_o,
                   if4.d5_o, if4.d4_o, if4.d3_o, if4.d2_o, if4.d1_o, if4.d0_o};
   assign ob[2] = {if83.busy_o, if83.frame_done_o, if83.rd_en_o, if83.rd_addr_o, if83.calc_valid_o,
                   if83.wr_en_o, if83.wr_addr_o, if83.wr_data_o, if83.d8_o, if83.d7_o, if83.d6_o,
                   if83.d5_o, if83.d4_o, if83.d3_o, if83.d2_o, if83.d1_o, if83.d0_o};
   assign o = ob[sel];

   // synchronous-read source RAM
   always @(posedge clk) if (o.rd_en) rd_data <= mem[o.rd_addr[5:0]];

   int         vectors = 0, errors = 0;
   int         rd_q[$], exp_rd[$];
   logic [23:0] wr_q[$], exp_wr[$], saved[$];
   win_t       win_q[$], exp_win[$];
   int         n_done, excl_err, hold_err, range_err, post_err;
   bit         timed_out, busy_at_done, rst_zero_bad;
   int         ws[3] = '{3, 4, 8};
   int         hs[3] = '{3, 4, 3};

   // mode 0: constant 32, mode 1: centre pixel, else an order-sensitive hash
   function automatic logic [7:0] calc_f(input win_t d, input int mode);
      logic [7:0] s;
      s = '0;
      if (mode == 0) return 8'd32;
      if (mode == 1) return d[4];
      for (int k = 0; k < 9; k++) s = s * 8'd3 + d[k];
      return s;
   endfunction

   task automatic fill_rand(input int n);
      for (int i = 0; i < 64; i++) mem[i] = (i < n) ? 8'($urandom) : 8'h00;
   endtask

   // expected reads, windows and writes straight from the image geometry
   task automatic build_model(input int w, h, mode);
      exp_rd.delete(); exp_wr.delete(); exp_win.delete();
      for (int y = 1; y <= h - 2; y++)
         for (int x = 1; x <= w - 2; x++) begin
            win_t wn;
            for (int k = 0; k < 9; k++) wn[k] = mem[(y - 1 + k / 3) * w + (x - 1 + k % 3)];
            exp_win.push_back(wn);
            exp_wr.push_back({16'((y - 1) * (w - 2) + (x - 1)), calc_f(wn, mode)});
            if (x == 1) begin
               for (int c = 0; c < 3; c++)
                  for (int r = 0; r < 3; r++) exp_rd.push_back((y - 1 + r) * w + c);
            end else
               for (int r = 0; r < 3; r++) exp_rd.push_back((y - 1 + r) * w + x + 1);
         end
   endtask

   // Starts a frame on the selected DUT and plays RAM + sobel_calc until done
   // (plus 4 idle cycles), or resets during WAIT of window rst_win when nonzero.
   task automatic run_frame(input int w, h, lat_lo, lat_hi, mode, input bit noise, input int rst_win);
      int lat_left = 0, post = 0;
      bit waiting = 0, finished = 0;
      logic [7:0] res = '0;
      win_t held = '0;
      rd_q.delete(); wr_q.delete(); win_q.delete();
      n_done = 0; excl_err = 0; hold_err = 0; range_err = 0; post_err = 0;
      timed_out = 1; busy_at_done = 0; rst_zero_bad = 0;
      start = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         start = 1'b0; cdone = 1'b0;
         if (finished) begin
            if (o.busy || o.rd_en || o.calc_valid || o.wr_en || o.frame_done) post_err++;
            post++;
            if (post == 4) begin timed_out = 0; return; end
            continue;
         end
         if (int'(o.rd_en) + int'(o.calc_valid) + int'(o.wr_en) + int'(o.frame_done) > 1) excl_err++;
         if (o.rd_en) begin
            rd_q.push_back(int'(o.rd_addr));
            if (int'(o.rd_addr) >= w * h) range_err++;
         end
         if (waiting && o.d !== held) hold_err++;
         if (o.calc_valid) begin
            win_q.push_back(o.d);
            held = o.d; res = calc_f(o.d, mode);
            lat_left = $urandom_range(lat_hi, lat_lo); waiting = 1;
         end else if (waiting) begin
            if (rst_win == win_q.size()) begin
               rst = 1'b0; #1;
               if (o !== '0) rst_zero_bad = 1;
               @(negedge clk); rst = 1'b1; timed_out = 0;
               return;
            end
            lat_left--;
            if (lat_left == 0) begin cdone = 1'b1; cpix = res; waiting = 0; end
         end
         if (o.wr_en) wr_q.push_back({o.wr_addr, o.wr_data});
         if (o.frame_done) begin
            n_done++; busy_at_done = o.busy; finished = 1;
            if (noise) start = 1'b1;
         end else if (noise && !waiting && !cdone) begin
            if ($urandom_range(3, 0) == 0) begin cdone = 1'b1; cpix = 8'($urandom); end
            if (o.busy && $urandom_range(7, 0) == 0) start = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s; #1; vectors++;
         if (o !== '0) begin errors++; $display("FAIL reset_out[%0d]: got %h want 0", s, o); end
      end
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s; #1; vectors++;
         if (o !== '0) begin errors++; $display("FAIL idle_out[%0d]: got %h want 0", s, o); end
      end
      @(negedge clk);
   endtask

   task automatic test_3x3;
      int   exp3[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
      win_t ew;
      sel = 0;
      for (int i = 0; i < 64; i++) mem[i] = (i < 9) ? 8'(i + 1) : 8'h00;
      for (int k = 0; k < 9; k++) ew[k] = 8'(k + 1);
      run_frame(3, 3, 3, 3, 0, 0, 0);
      vectors++; if (timed_out) begin errors++; $display("FAIL 3x3 timeout: got 1 want 0"); end
      vectors++;
      if (rd_q.size() != 9) begin errors++; $display("FAIL 3x3 rd_count: got %0d want 9", rd_q.size()); end
      else foreach (exp3[i]) begin
         vectors++;
         if (rd_q[i] != exp3[i]) begin errors++; $display("FAIL 3x3 rd[%0d]: got %0d want %0d", i, rd_q[i], exp3[i]); end
      end
      vectors++;
      if (win_q.size() != 1 || win_q[0] !== ew) begin
         errors++; $display("FAIL 3x3 window: got n=%0d %h want n=1 %h", win_q.size(), win_q.size() ? win_q[0] : '0, ew);
      end
      vectors++;
      if (wr_q.size() != 1 || wr_q[0] !== {16'd0, 8'd32}) begin
         errors++; $display("FAIL 3x3 write: got n=%0d %h want n=1 000020", wr_q.size(), wr_q.size() ? wr_q[0] : '0);
      end
      vectors++;
      if (n_done != 1 || busy_at_done) begin
         errors++; $display("FAIL 3x3 done: got n=%0d busy=%0d want n=1 busy=0", n_done, busy_at_done);
      end
      vectors++;
      if (excl_err + hold_err + range_err + post_err != 0) begin
         errors++; $display("FAIL 3x3 protocol: got excl=%0d hold=%0d range=%0d post=%0d want 0", excl_err, hold_err, range_err, post_err);
      end
   endtask

   task automatic test_4x4_center;
      sel = 1;
      for (int i = 0; i < 64; i++) mem[i] = 8'(i);
      build_model(4, 4, 1);
      run_frame(4, 4, 1, 7, 1, 0, 0);
      vectors++;
      if (rd_q.size() != 24) begin errors++; $display("FAIL 4x4 rd_count: got %0d want 24", rd_q.size()); end
      else foreach (exp_rd[i]) begin
         vectors++;
         if (rd_q[i] != exp_rd[i]) begin errors++; $display("FAIL 4x4 rd[%0d]: got %0d want %0d", i, rd_q[i], exp_rd[i]); end
      end
      vectors++;
      if (wr_q.size() != 4) begin errors++; $display("FAIL 4x4 wr_count: got %0d want 4", wr_q.size()); end
      else foreach (exp_wr[i]) begin
         vectors++;
         if (wr_q[i] !== exp_wr[i]) begin errors++; $display("FAIL 4x4 wr[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]); end
      end
      vectors++;
      if (timed_out || n_done != 1 || excl_err + hold_err + range_err + post_err != 0) begin
         errors++; $display("FAIL 4x4 protocol: got to=%0d done=%0d excl=%0d hold=%0d range=%0d post=%0d want 0/1/0/0/0/0",
                            timed_out, n_done, excl_err, hold_err, range_err, post_err);
      end
   endtask

   task automatic test_latency;
      sel = 1; fill_rand(16); build_model(4, 4, 2);
      run_frame(4, 4, 1, 1, 2, 0, 0);
      saved = wr_q;
      run_frame(4, 4, 7, 7, 2, 0, 0);
      vectors++;
      if (saved.size() != exp_wr.size() || wr_q.size() != exp_wr.size()) begin
         errors++; $display("FAIL latency wr_count: got %0d/%0d want %0d", saved.size(), wr_q.size(), exp_wr.size());
      end else foreach (exp_wr[i]) begin
         vectors++;
         if (saved[i] !== exp_wr[i] || wr_q[i] !== exp_wr[i]) begin
            errors++; $display("FAIL latency wr[%0d]: got %h/%h want %h", i, saved[i], wr_q[i], exp_wr[i]);
         end
      end
      vectors++;
      if (hold_err != 0 || n_done != 1) begin
         errors++; $display("FAIL latency hold: got hold=%0d done=%0d want 0/1", hold_err, n_done);
      end
   endtask

   task automatic test_noise;
      sel = 1; fill_rand(16); build_model(4, 4, 2);
      run_frame(4, 4, 1, 4, 2, 1, 0);
      vectors++;
      if (wr_q.size() != exp_wr.size() || rd_q.size() != exp_rd.size()) begin
         errors++; $display("FAIL noise count: got wr=%0d rd=%0d want wr=%0d rd=%0d", wr_q.size(), rd_q.size(), exp_wr.size(), exp_rd.size());
      end else foreach (exp_wr[i]) begin
         vectors++;
         if (wr_q[i] !== exp_wr[i]) begin errors++; $display("FAIL noise wr[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]); end
      end
      vectors++;
      if (timed_out || n_done != 1 || post_err != 0 || excl_err != 0) begin
         errors++; $display("FAIL noise protocol: got to=%0d done=%0d post=%0d excl=%0d want 0/1/0/0", timed_out, n_done, post_err, excl_err);
      end
   endtask

   task automatic test_reset_midframe;
      sel = 1; fill_rand(16); build_model(4, 4, 2);
      run_frame(4, 4, 3, 6, 2, 0, 2);
      vectors++;
      if (rst_zero_bad) begin errors++; $display("FAIL midreset outputs: got nonzero want 0"); end
      vectors++;
      if (n_done != 0 || wr_q.size() != 1) begin
         errors++; $display("FAIL midreset abort: got done=%0d wr=%0d want 0/1", n_done, wr_q.size());
      end
      run_frame(4, 4, 1, 3, 2, 0, 0);
      vectors++;
      if (wr_q.size() != 4 || rd_q.size() != 24) begin
         errors++; $display("FAIL restart count: got wr=%0d rd=%0d want 4/24", wr_q.size(), rd_q.size());
      end else foreach (exp_wr[i]) begin
         vectors++;
         if (wr_q[i] !== exp_wr[i]) begin errors++; $display("FAIL restart wr[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]); end
      end
   endtask

   task automatic test_wide;
      sel = 2; fill_rand(24); build_model(8, 3, 2);
      run_frame(8, 3, 1, 5, 2, 0, 0);
      vectors++;
      if (rd_q.size() != 24) begin errors++; $display("FAIL wide rd_count: got %0d want 24", rd_q.size()); end
      else foreach (exp_rd[i]) begin
         vectors++;
         if (rd_q[i] != exp_rd[i]) begin errors++; $display("FAIL wide rd[%0d]: got %0d want %0d", i, rd_q[i], exp_rd[i]); end
      end
      vectors++;
      if (wr_q.size() != 6) begin errors++; $display("FAIL wide wr_count: got %0d want 6", wr_q.size()); end
      else foreach (exp_wr[i]) begin
         vectors++;
         if (wr_q[i] !== exp_wr[i]) begin errors++; $display("FAIL wide wr[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]); end
      end
      vectors++;
      if (n_done != 1 || excl_err + hold_err + range_err + post_err != 0) begin
         errors++; $display("FAIL wide protocol: got done=%0d excl=%0d hold=%0d range=%0d post=%0d want 1/0/0/0/0",
                            n_done, excl_err, hold_err, range_err, post_err);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 6; it++) begin
         int w, h;
         sel = $urandom_range(2, 0);
         w = ws[sel]; h = hs[sel];
         fill_rand(w * h); build_model(w, h, 2);
         run_frame(w, h, 1, 6, 2, 1'($urandom), 0);
         vectors++;
         if (wr_q.size() != exp_wr.size() || rd_q.size() != exp_rd.size() || win_q.size() != exp_win.size()) begin
            errors++; $display("FAIL random[%0d] count: got wr=%0d rd=%0d win=%0d want %0d/%0d/%0d", it,
                               wr_q.size(), rd_q.size(), win_q.size(), exp_wr.size(), exp_rd.size(), exp_win.size());
         end else foreach (exp_win[i]) begin
            vectors++;
            if (win_q[i] !== exp_win[i] || wr_q[i] !== exp_wr[i]) begin
               errors++; $display("FAIL random[%0d] win[%0d]: got %h/%h want %h/%h", it, i, win_q[i], wr_q[i], exp_win[i], exp_wr[i]);
            end
         end
         vectors++;
         if (timed_out || n_done != 1 || excl_err + hold_err + range_err + post_err != 0) begin
            errors++; $display("FAIL random[%0d] protocol: got to=%0d done=%0d excl=%0d hold=%0d range=%0d post=%0d", it,
                               timed_out, n_done, excl_err, hold_err, range_err, post_err);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      test_reset();
      test_3x3();
      test_4x4_center();
      test_latency();
      test_noise();
      test_reset_midframe();
      test_wide();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/sobel_ctrl.md
Name: sobel_ctrl

Overview:
- Frame scheduler for the sobel_calc datapath.
- Walks a grayscale image held in a synchronous-read source RAM and builds each interior 3x3 neighbourhood with a column-shift window.
- Presents each window to sobel_calc, waits for its result, and writes that result to a destination RAM.
- One window is in flight at a time; sobel_calc latency is not assumed.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- ADDR_W, 16, RAM address width; must hold IMG_W*IMG_H-1

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  1-cycle pulse starts a frame; ignored while busy_o=1
- busy_o  out  1  high from the cycle after an accepted start until frame_done_o
- frame_done_o  out  1  1-cycle pulse after the last result is written
- rd_en_o  out  1  source RAM read strobe
- rd_addr_o  out  ADDR_W  source address = y*IMG_W+x
- rd_data_i  in  8  source data, valid the cycle after rd_en_o
- d0_o..d8_o  out  8 each  window to sobel_calc: d0 d1 d2 = row y-1, d3 d4 d5 = row y, d6 d7 d8 = row y+1; left to right = x-1, x, x+1
- calc_valid_o  out  1  drives sobel_calc done_i; 1-cycle pulse per window
- calc_done_i  in  1  from sobel_calc done_o
- calc_pix_i  in  8  from sobel_calc grayscale_o
- wr_en_o  out  1  destination write strobe
- wr_addr_o  out  ADDR_W  destination address = (y-1)*(IMG_W-2)+(x-1)
- wr_data_o  out  8  result pixel

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including d*_o and the address outputs. Reset mid-frame aborts the frame with no frame_done_o; the next start_i after release begins at window (1,1).
- States and transitions:
  - IDLE: wait for start_i. On start, set y=1, x=1, go to FILL.
  - FILL: 9 consecutive rd_en_o cycles, column-major: x-1 (rows y-1,y,y+1), then x, then x+1. Data is captured one cycle later into the matching d register. The last datum lands 10 cycles after FILL entry; then go to ISSUE.
  - ISSUE: calc_valid_o=1 for exactly 1 cycle; go to WAIT.
  - WAIT: hold d*_o stable. On calc_done_i=1, latch calc_pix_i into wr_data_o and go to WRITE.
  - WRITE: wr_en_o=1 for 1 cycle with wr_addr_o/wr_data_o. Then:
    - x<IMG_W-2: x++, go to COL.
    - else if y<IMG_H-2: y++, x=1, go to FILL.
    - else go to DONE.
  - COL: shift the window left (left column <= middle, middle <= right), then read column x+1 (rows y-1,y,y+1; 3 rd_en_o cycles). The new right column is complete 4 cycles after COL entry; go to ISSUE.
  - DONE: frame_done_o=1 for 1 cycle, busy_o drops in the same cycle, return to IDLE.
- rd_en_o, calc_valid_o, wr_en_o, frame_done_o are never asserted together.
- calc_done_i outside WAIT is ignored.
- Addresses never leave 0..IMG_W*IMG_H-1. Window coordinates stay within 1..IMG_W-2 and 1..IMG_H-2.
- Total writes per frame = (IMG_W-2)*(IMG_H-2), written in raster order at addresses 0 upward.
- start_i during busy: ignored. start_i in the same cycle as frame_done_o: ignored.
- rd_addr_o holds its last value when rd_en_o=0.

Test Plan:
- IMG_W=IMG_H=3, RAM holds 1..9 row-major; bench sobel_calc model returns 32 after 3 cycles -> reads at addresses 0,3,6,1,4,7,2,5,8; one calc_valid_o with d0..d8=1..9; single write addr 0 data 32; frame_done_o pulse; busy_o low afterwards.
- IMG_W=IMG_H=4, pixel = y*4+x, model returns d4 -> writes data 5,6,9,10 to addr 0..3. Read counts:
  - FILL 9 reads at row start, COL 3 reads per subsequent window.
  - Second window reads addrs 3,7,11 only.
- Model latency 1 vs 7 -> identical write sequence. d*_o stays constant throughout WAIT.
- start_i pulsed mid-frame, and spurious calc_done_i during FILL -> no effect on addresses, write count, or data.
- rst dropped during WAIT of window 2 (4x4 frame) -> all outputs 0 immediately. Restart produces a full 4-write frame from addr 0.
- IMG_W=8, IMG_H=3 -> 6 writes at addr 0..5, then frame_done_o. Exactly one FILL occurs (9 reads), followed by 5 COLs.
